// File: rtl/clock_monitor.sv
// Clock activity monitor: synchronizes a slow toggling clock into i_clk, emits edge pulses,
// measures the half-period in i_clk cycles and flags a source that stops toggling.
module clock_monitor #(
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 16,
    parameter int TIMEOUT     = 1000
) (
    input  logic             i_clk,
    input  logic             i_reset_n,
    input  logic             i_gen_clk,
    input  logic             i_clear,
    output logic             o_level,
    output logic             o_rise,
    output logic             o_fall,
    output logic             o_roll_over,
    output logic [CNT_W-1:0] o_half_period,
    output logic             o_valid,
    output logic             o_stuck,
    output logic [1:0]       o_dbg_state
);

    typedef enum logic [1:0] {
        WAIT_FIRST = 2'd0,
        MEASURE    = 2'd1,
        STUCK      = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   hist_q;
    logic                   edge_rise;
    logic                   edge_fall;
    logic                   edge_any;
    logic                   rise_q;
    logic                   fall_q;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] cnt_inc;
    logic [CNT_W-1:0] half_q, half_d;
    logic             valid_q, valid_d;
    logic             stuck_q, stuck_d;
    logic             timeout_hit;

    // Flops preset to 1 so a source idling high after reset release yields no edge.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            sync_q <= '1;
            hist_q <= 1'b1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], i_gen_clk};
            hist_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign edge_rise = sync_q[SYNC_STAGES-1] & ~hist_q;
    assign edge_fall = ~sync_q[SYNC_STAGES-1] & hist_q;
    assign edge_any  = edge_rise | edge_fall;

    // Edge pulses are independent of i_clear: a clear never swallows an edge pulse.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            rise_q <= edge_rise;
            fall_q <= edge_fall;
        end
    end

    assign cnt_inc     = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;
    assign timeout_hit = (cnt_q == TIMEOUT_C);

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q <= WAIT_FIRST;
            cnt_q   <= '0;
            half_q  <= '0;
            valid_q <= 1'b0;
            stuck_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            half_q  <= half_d;
            valid_q <= valid_d;
            stuck_q <= stuck_d;
        end
    end

    // An edge always beats the timeout; i_clear beats everything.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        half_d  = half_q;
        valid_d = valid_q;
        stuck_d = stuck_q;
        if (i_clear) begin
            state_d = WAIT_FIRST;
            cnt_d   = '0;
            valid_d = 1'b0;
            stuck_d = 1'b0;
        end else begin
            case (state_q)
                WAIT_FIRST: begin
                    if (edge_any) begin
                        state_d = MEASURE;
                        cnt_d   = CNT_ONE;
                    end else if (timeout_hit) begin
                        state_d = STUCK;
                        stuck_d = 1'b1;
                        valid_d = 1'b0;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                MEASURE: begin
                    if (edge_any) begin
                        half_d  = cnt_q;
                        valid_d = 1'b1;
                        cnt_d   = CNT_ONE;
                    end else if (timeout_hit) begin
                        state_d = STUCK;
                        stuck_d = 1'b1;
                        valid_d = 1'b0;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                STUCK: begin
                    // Recovery restarts measuring, but the sticky flag waits for i_clear.
                    valid_d = 1'b0;
                    if (edge_any) begin
                        state_d = MEASURE;
                        cnt_d   = CNT_ONE;
                    end
                end
                default: begin
                    state_d = WAIT_FIRST;
                end
            endcase
        end
    end

    assign o_level       = sync_q[SYNC_STAGES-1];
    assign o_rise        = rise_q;
    assign o_fall        = fall_q;
    assign o_roll_over   = rise_q | fall_q;
    assign o_half_period = half_q;
    assign o_valid       = valid_q;
    assign o_stuck       = stuck_q;
    assign o_dbg_state   = state_q;

endmodule

// File: tb/tb_clock_monitor.sv
// Randomized bench for clock_monitor: two instances with different parameters, each checked
// every cycle against a timestamp-based reference model of the monitor's behaviour.
module tb_clock_monitor;

    localparam int S_A = 2;
    localparam int W_A = 16;
    localparam int T_A = 50;
    localparam int S_B = 3;
    localparam int W_B = 4;
    localparam int T_B = 15;

    localparam int M_WAIT  = 0;
    localparam int M_MEAS  = 1;
    localparam int M_STUCK = 2;

    logic           clk   = 1'b0;
    logic           rst_n = 1'b0;
    logic           gen_a = 1'b1;
    logic           gen_b = 1'b1;
    logic           clr_a = 1'b0;
    logic           clr_b = 1'b0;

    logic           lvl_a, rise_a, fall_a, roll_a, val_a, stk_a;
    logic [W_A-1:0] half_a;
    logic [1:0]     dbg_a;
    logic           lvl_b, rise_b, fall_b, roll_b, val_b, stk_b;
    logic [W_B-1:0] half_b;
    logic [1:0]     dbg_b;

    int checks = 0;
    int errors = 0;
    int ca = 0;
    int cb = 0;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    clock_monitor #(.SYNC_STAGES(S_A), .CNT_W(W_A), .TIMEOUT(T_A)) dut_a (
        .i_clk(clk), .i_reset_n(rst_n), .i_gen_clk(gen_a), .i_clear(clr_a),
        .o_level(lvl_a), .o_rise(rise_a), .o_fall(fall_a), .o_roll_over(roll_a),
        .o_half_period(half_a), .o_valid(val_a), .o_stuck(stk_a), .o_dbg_state(dbg_a)
    );

    clock_monitor #(.SYNC_STAGES(S_B), .CNT_W(W_B), .TIMEOUT(T_B)) dut_b (
        .i_clk(clk), .i_reset_n(rst_n), .i_gen_clk(gen_b), .i_clear(clr_b),
        .o_level(lvl_b), .o_rise(rise_b), .o_fall(fall_b), .o_roll_over(roll_b),
        .o_half_period(half_b), .o_valid(val_b), .o_stuck(stk_b), .o_dbg_state(dbg_b)
    );

    // ---------------- reference model ----------------
    // g_hist[d][k] is the level sampled k posedges ago. Timing is tracked as posedge
    // timestamps: anchor0 is the cycle at which the idle count was notionally zero.
    int  sv[2] = '{S_A, S_B};
    int  tv[2] = '{T_A, T_B};
    int  mx[2] = '{(1 << W_A) - 1, (1 << W_B) - 1};
    bit  g_hist[2][8];
    int  m_cyc[2], anchor0[2], last_edge[2], mode[2];
    bit  e_level[2], e_rise[2], e_fall[2], e_valid[2], e_stuck[2];
    int  e_half[2];

    task automatic model_reset(input int d);
        for (int k = 0; k < 8; k++) g_hist[d][k] = 1'b1;
        m_cyc[d]     = 0;
        anchor0[d]   = -1;
        last_edge[d] = 0;
        mode[d]      = M_WAIT;
        e_level[d]   = 1'b1;
        e_rise[d]    = 1'b0;
        e_fall[d]    = 1'b0;
        e_valid[d]   = 1'b0;
        e_stuck[d]   = 1'b0;
        e_half[d]    = 0;
    endtask

    task automatic model_step(input int d, input bit g, input bit clr);
        int s;
        int p;
        bit e;
        s = sv[d];
        for (int k = 7; k > 0; k--) g_hist[d][k] = g_hist[d][k-1];
        g_hist[d][0] = g;
        p = m_cyc[d];
        e = g_hist[d][s] != g_hist[d][s+1];
        e_level[d] = g_hist[d][s-1];
        e_rise[d]  = g_hist[d][s] & ~g_hist[d][s+1];
        e_fall[d]  = ~g_hist[d][s] & g_hist[d][s+1];
        if (clr) begin
            e_stuck[d] = 1'b0;
            e_valid[d] = 1'b0;
            mode[d]    = M_WAIT;
            anchor0[d] = p;
        end else if (e) begin
            if (mode[d] == M_MEAS) begin
                e_half[d]  = (p - last_edge[d] > mx[d]) ? mx[d] : p - last_edge[d];
                e_valid[d] = 1'b1;
            end
            mode[d]      = M_MEAS;
            anchor0[d]   = p - 1;
            last_edge[d] = p;
        end else if (mode[d] != M_STUCK && p - anchor0[d] == tv[d] + 1) begin
            mode[d]    = M_STUCK;
            e_stuck[d] = 1'b1;
            e_valid[d] = 1'b0;
        end
        m_cyc[d] = m_cyc[d] + 1;
    endtask

    // ---------------- scoreboard ----------------
    task automatic check(input string tag, input longint got, input longint exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, got, exp);
        end
    endtask

    task automatic check_all();
        check("a_level", lvl_a, e_level[0]);
        check("a_rise", rise_a, e_rise[0]);
        check("a_fall", fall_a, e_fall[0]);
        check("a_roll", roll_a, e_rise[0] | e_fall[0]);
        check("a_half", half_a, e_half[0]);
        check("a_valid", val_a, e_valid[0]);
        check("a_stuck", stk_a, e_stuck[0]);
        check("a_state_legal", longint'(dbg_a <= 2'd2), 1);
        check("b_level", lvl_b, e_level[1]);
        check("b_rise", rise_b, e_rise[1]);
        check("b_fall", fall_b, e_fall[1]);
        check("b_roll", roll_b, e_rise[1] | e_fall[1]);
        check("b_half", half_b, e_half[1]);
        check("b_valid", val_b, e_valid[1]);
        check("b_stuck", stk_b, e_stuck[1]);
        check("b_state_legal", longint'(dbg_b <= 2'd2), 1);
    endtask

    // ---------------- driver tasks ----------------
    // Inputs change just after a negedge; model advances on the posedge; outputs checked at negedge.
    task automatic tick();
        @(posedge clk);
        if (rst_n) begin
            model_step(0, gen_a, clr_a);
            model_step(1, gen_b, clr_b);
        end
        @(negedge clk);
        check_all();
    endtask

    // Period 0 freezes a source; rnd picks a fresh half-period at each toggle plus sparse clears.
    task automatic run(input int n, input int pa, input int pb, input bit rnd);
        for (int i = 0; i < n; i++) begin
            if (pa != 0) begin
                ca--;
                if (ca <= 0) begin
                    gen_a = ~gen_a;
                    ca = rnd ? (($urandom_range(0, 9) == 0) ? 55 : int'($urandom_range(2, 14))) : pa;
                end
            end
            if (pb != 0) begin
                cb--;
                if (cb <= 0) begin
                    gen_b = ~gen_b;
                    cb = rnd ? int'($urandom_range(2, 20)) : pb;
                end
            end
            if (rnd) begin
                clr_a = ($urandom_range(0, 39) == 0);
                clr_b = ($urandom_range(0, 39) == 0);
            end
            tick();
        end
        clr_a = 1'b0;
        clr_b = 1'b0;
    endtask

    task automatic async_reset();
        rst_n = 1'b0;
        #1;
        model_reset(0);
        model_reset(1);
        check_all();
        check("rst_valid", val_a, 0);
        check("rst_level", lvl_a, 1);
        tick();
        rst_n = 1'b1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        model_reset(0);
        model_reset(1);
        repeat (3) tick();
        check("reset_half", half_a, 0);
        check("reset_level", lvl_a, 1);
        rst_n = 1'b1;

        run(20, 0, 0, 1'b0);
        check("idle_level", lvl_a, 1);
        check("idle_valid", val_a, 0);
        check("idle_stuck", stk_a, 0);

        run(120, 8, 20, 1'b0);
        check("half_8", half_a, 8);
        check("valid_8", val_a, 1);
        check("b_never_measured", half_b, 0);
        check("b_stuck", stk_b, 1);

        run(60, 0, 20, 1'b0);
        check("frozen_stuck", stk_a, 1);
        check("frozen_valid", val_a, 0);

        run(30, 6, 0, 1'b0);
        check("stuck_sticky", stk_a, 1);

        clr_a = 1'b1;
        clr_b = 1'b1;
        tick();
        clr_a = 1'b0;
        clr_b = 1'b0;
        check("clear_stuck", stk_a, 0);
        check("clear_valid", val_a, 0);

        run(40, 6, 9, 1'b0);
        check("half_6", half_a, 6);
        check("valid_6", val_a, 1);

        run(800, 1, 1, 1'b1);

        run(11, 7, 7, 1'b0);
        async_reset();
        run(40, 7, 7, 1'b0);
        check("post_reset_half", half_a, 7);

        run(400, 1, 1, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
